// File: rtl/oob_sequencer.sv
// Host-side out-of-band link sequencer. It runs the COMRESET and COMWAKE exchange,
// locks in on ALIGN and SYNC, watches for link loss in READY, and retries a bounded number of times.
//
// state        | meaning
// -------------+--------------------------------------------------------
// IDLE         | tx idle, waiting for platform_ready
// SEND_RESET   | COMRESET burst in flight
// WAIT_INIT    | waiting for device COMINIT
// WAIT_NO_INIT | waiting for COMINIT to end, then issue COMWAKE
// SEND_WAKE    | COMWAKE burst in flight
// WAIT_WAKE    | waiting for device COMWAKE
// WAIT_NO_WAKE | waiting for COMWAKE to end
// WAIT_ALIGN   | sending dial tone, waiting for ALIGN
// SEND_ALIGN   | sending ALIGN until the device stops sending ALIGN
// DETECT_SYNC  | sending ALIGN, waiting for SYNC
// READY        | link up, watching for COMINIT or electrical idle
// FAIL         | retries exhausted, waiting for platform_ready low
module oob_sequencer #(
   parameter logic [31:0] RESET_CYCLES   = 32'd162,
   parameter logic [31:0] WAKE_CYCLES    = 32'd155,
   parameter logic [31:0] INIT_TIMEOUT   = 32'h00040000,
   parameter logic [31:0] NO_INIT_CYCLES = 32'h00001000,
   parameter logic [31:0] WAKE_TIMEOUT   = 32'h000203AD,
   parameter logic [31:0] ALIGN_TIMEOUT  = 32'h000203AD,
   parameter int unsigned MAX_RETRIES    = 4,
   parameter int unsigned ALIGN_RELEASE  = 4,
   parameter bit          REQUIRE_SYNC   = 1'b1,
   parameter int unsigned LOSS_CYCLES    = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        platform_ready,
   input  logic        tx_oob_complete,
   input  logic        comm_init_detect,
   input  logic        comm_wake_detect,
   input  logic [31:0] rx_din,
   input  logic [3:0]  rx_is_k,
   input  logic        rx_byte_is_aligned,
   input  logic        rx_is_elec_idle,
   output logic        tx_comm_reset,
   output logic        tx_comm_wake,
   output logic [31:0] tx_dout,
   output logic        tx_is_k,
   output logic        tx_set_elec_idle,
   output logic        linkup,
   output logic        platform_error,
   output logic [3:0]  retry_count,
   output logic [3:0]  lax_state
);

   localparam logic [31:0] ALIGN_PRIM  = 32'h7B4A4ABC;
   localparam logic [31:0] SYNC_PRIM   = 32'hB5B5957C;
   localparam logic [31:0] DIALTONE    = 32'h4A4A4A4A;
   localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRIES);
   localparam logic [3:0]  REL_LIMIT   = 4'(ALIGN_RELEASE);
   localparam logic [7:0]  LOSS_LIMIT  = 8'(LOSS_CYCLES);

   typedef enum logic [3:0] {
      ST_IDLE         = 4'h0,
      ST_SEND_RESET   = 4'h1,
      ST_WAIT_INIT    = 4'h2,
      ST_WAIT_NO_INIT = 4'h3,
      ST_SEND_WAKE    = 4'h4,
      ST_WAIT_WAKE    = 4'h5,
      ST_WAIT_NO_WAKE = 4'h6,
      ST_WAIT_ALIGN   = 4'h7,
      ST_SEND_ALIGN   = 4'h8,
      ST_DETECT_SYNC  = 4'h9,
      ST_READY        = 4'hA,
      ST_FAIL         = 4'hB
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] timer;
   logic [31:0] timer_nxt;
   logic [3:0]  retry_nxt;
   logic [3:0]  rel_cnt;
   logic [3:0]  rel_nxt;
   logic [7:0]  loss_cnt;
   logic [7:0]  loss_nxt;
   logic        retry_evt;
   logic        timeout;
   logic        align_det;
   logic        sync_det;

   assign timeout   = (timer == 32'd0);
   assign align_det = (rx_is_k != 4'd0) && (rx_din == ALIGN_PRIM) && rx_byte_is_aligned;
   assign sync_det  = (rx_is_k != 4'd0) && (rx_din == SYNC_PRIM);
   assign lax_state = state;

   always_comb begin
      state_nxt = state;
      timer_nxt = (timer != 32'd0) ? timer - 32'd1 : timer;
      retry_nxt = retry_count;
      rel_nxt   = rel_cnt;
      loss_nxt  = loss_cnt;
      retry_evt = 1'b0;
      case (state)
         ST_IDLE:
            if (platform_ready) state_nxt = ST_SEND_RESET;
         ST_SEND_RESET:
            if (timeout || tx_oob_complete) state_nxt = ST_WAIT_INIT;
         ST_WAIT_INIT:
            if (comm_init_detect) state_nxt = ST_WAIT_NO_INIT;
            else if (timeout)     retry_evt = 1'b1;
         ST_WAIT_NO_INIT:
            if (!comm_init_detect && (timeout || tx_oob_complete)) state_nxt = ST_SEND_WAKE;
         ST_SEND_WAKE:
            if (timeout || tx_oob_complete) state_nxt = ST_WAIT_WAKE;
         ST_WAIT_WAKE:
            if (comm_wake_detect) state_nxt = ST_WAIT_NO_WAKE;
            else if (timeout)     retry_evt = 1'b1;
         ST_WAIT_NO_WAKE:
            if (!comm_wake_detect) state_nxt = ST_WAIT_ALIGN;
         ST_WAIT_ALIGN:
            if (align_det)    state_nxt = ST_SEND_ALIGN;
            else if (timeout) retry_evt = 1'b1;
         ST_SEND_ALIGN:
            // only an unbroken run of non-ALIGN words releases the state
            if (align_det)
               rel_nxt = 4'd0;
            else if (rel_cnt + 4'd1 == REL_LIMIT)
               state_nxt = REQUIRE_SYNC ? ST_DETECT_SYNC : ST_READY;
            else
               rel_nxt = rel_cnt + 4'd1;
         ST_DETECT_SYNC:
            if (sync_det)     state_nxt = ST_READY;
            else if (timeout) retry_evt = 1'b1;
         ST_READY:
            if (comm_init_detect)
               state_nxt = ST_IDLE;
            else if (rx_is_elec_idle) begin
               if (loss_cnt + 8'd1 == LOSS_LIMIT) state_nxt = ST_IDLE;
               else                               loss_nxt  = loss_cnt + 8'd1;
            end else
               loss_nxt = 8'd0;
         ST_FAIL:
            if (!platform_ready) begin
               state_nxt = ST_IDLE;
               retry_nxt = 4'd0;
            end
         default:
            state_nxt = ST_IDLE;
      endcase

      if (retry_evt) begin
         if (retry_count + 4'd1 == RETRY_LIMIT) begin
            state_nxt = ST_FAIL;
         end else begin
            retry_nxt = retry_count + 4'd1;
            state_nxt = ST_IDLE;
         end
      end

      // losing the platform clocks aborts any sequence in progress without counting a retry
      if (!platform_ready && state != ST_IDLE && state != ST_FAIL) begin
         state_nxt = ST_IDLE;
         retry_nxt = retry_count;
      end

      if (state_nxt == ST_READY) retry_nxt = 4'd0;

      if (state_nxt != state) begin
         rel_nxt  = 4'd0;
         loss_nxt = 8'd0;
         case (state_nxt)
            ST_SEND_RESET:   timer_nxt = RESET_CYCLES;
            ST_WAIT_INIT:    timer_nxt = INIT_TIMEOUT;
            ST_WAIT_NO_INIT: timer_nxt = NO_INIT_CYCLES;
            ST_SEND_WAKE:    timer_nxt = WAKE_CYCLES;
            ST_WAIT_WAKE:    timer_nxt = WAKE_TIMEOUT;
            ST_WAIT_ALIGN:   timer_nxt = ALIGN_TIMEOUT;
            ST_DETECT_SYNC:  timer_nxt = ALIGN_TIMEOUT;
            default:         timer_nxt = 32'd0;
         endcase
      end
   end

   // outputs are decoded from the next state so they line up with lax_state
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         timer            <= 32'd0;
         retry_count      <= 4'd0;
         rel_cnt          <= 4'd0;
         loss_cnt         <= 8'd0;
         tx_comm_reset    <= 1'b0;
         tx_comm_wake     <= 1'b0;
         tx_dout          <= 32'd0;
         tx_is_k          <= 1'b0;
         tx_set_elec_idle <= 1'b1;
         linkup           <= 1'b0;
         platform_error   <= 1'b0;
      end else begin
         state          <= state_nxt;
         timer          <= timer_nxt;
         retry_count    <= retry_nxt;
         rel_cnt        <= rel_nxt;
         loss_cnt       <= loss_nxt;
         tx_comm_reset  <= (state == ST_IDLE) && (state_nxt == ST_SEND_RESET);
         tx_comm_wake   <= (state == ST_WAIT_NO_INIT) && (state_nxt == ST_SEND_WAKE);
         linkup         <= (state_nxt == ST_READY);
         platform_error <= (state_nxt == ST_FAIL);
         case (state_nxt)
            ST_WAIT_ALIGN: begin
               tx_set_elec_idle <= 1'b0;
               tx_dout          <= DIALTONE;
               tx_is_k          <= 1'b0;
            end
            ST_SEND_ALIGN, ST_DETECT_SYNC, ST_READY: begin
               tx_set_elec_idle <= 1'b0;
               tx_dout          <= ALIGN_PRIM;
               tx_is_k          <= 1'b1;
            end
            default: begin
               tx_set_elec_idle <= 1'b1;
               tx_dout          <= 32'd0;
               tx_is_k          <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_oob_sequencer.sv
// Bench for oob_sequencer: a reference model keyed on time-in-state is compared every cycle,
// and directed scenarios add literal expectations.
module tb_oob_sequencer;

   localparam logic [31:0] ALIGN_W = 32'h7B4A4ABC;
   localparam logic [31:0] SYNC_W  = 32'hB5B5957C;
   localparam logic [31:0] DIAL_W  = 32'h4A4A4A4A;

   localparam int P_RESET    = 6;
   localparam int P_WAKE     = 5;
   localparam int P_INIT_TO  = 40;
   localparam int P_NOINIT   = 8;
   localparam int P_WAKE_TO  = 40;
   localparam int P_ALIGN_TO = 30;
   localparam int P_MAX      = 2;
   localparam int P_REL      = 4;
   localparam int P_LOSS     = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        platform_ready = 1'b0;
   logic        tx_oob_complete = 1'b0;
   logic        comm_init_detect = 1'b0;
   logic        comm_wake_detect = 1'b0;
   logic [31:0] rx_din = 32'd0;
   logic [3:0]  rx_is_k = 4'd0;
   logic        rx_byte_is_aligned = 1'b0;
   logic        rx_is_elec_idle = 1'b0;

   logic        tx_comm_reset, tx_comm_wake, tx_is_k, tx_set_elec_idle, linkup, platform_error;
   logic [31:0] tx_dout;
   logic [3:0]  retry_count, lax_state;

   logic        b_comm_reset, b_comm_wake, b_is_k, b_elec_idle, b_linkup, b_error;
   logic [31:0] b_dout;
   logic [3:0]  b_retry, b_state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   oob_sequencer #(
      .RESET_CYCLES(P_RESET), .WAKE_CYCLES(P_WAKE), .INIT_TIMEOUT(P_INIT_TO),
      .NO_INIT_CYCLES(P_NOINIT), .WAKE_TIMEOUT(P_WAKE_TO), .ALIGN_TIMEOUT(P_ALIGN_TO),
      .MAX_RETRIES(P_MAX), .ALIGN_RELEASE(P_REL), .REQUIRE_SYNC(1'b1), .LOSS_CYCLES(P_LOSS)
   ) dut (
      .clk(clk), .rst(rst), .platform_ready(platform_ready), .tx_oob_complete(tx_oob_complete),
      .comm_init_detect(comm_init_detect), .comm_wake_detect(comm_wake_detect),
      .rx_din(rx_din), .rx_is_k(rx_is_k), .rx_byte_is_aligned(rx_byte_is_aligned),
      .rx_is_elec_idle(rx_is_elec_idle), .tx_comm_reset(tx_comm_reset), .tx_comm_wake(tx_comm_wake),
      .tx_dout(tx_dout), .tx_is_k(tx_is_k), .tx_set_elec_idle(tx_set_elec_idle), .linkup(linkup),
      .platform_error(platform_error), .retry_count(retry_count), .lax_state(lax_state)
   );

   oob_sequencer #(
      .RESET_CYCLES(P_RESET), .WAKE_CYCLES(P_WAKE), .INIT_TIMEOUT(P_INIT_TO),
      .NO_INIT_CYCLES(P_NOINIT), .WAKE_TIMEOUT(P_WAKE_TO), .ALIGN_TIMEOUT(P_ALIGN_TO),
      .MAX_RETRIES(P_MAX), .ALIGN_RELEASE(P_REL), .REQUIRE_SYNC(1'b0), .LOSS_CYCLES(P_LOSS)
   ) dut_nosync (
      .clk(clk), .rst(rst), .platform_ready(platform_ready), .tx_oob_complete(tx_oob_complete),
      .comm_init_detect(comm_init_detect), .comm_wake_detect(comm_wake_detect),
      .rx_din(rx_din), .rx_is_k(rx_is_k), .rx_byte_is_aligned(rx_byte_is_aligned),
      .rx_is_elec_idle(rx_is_elec_idle), .tx_comm_reset(b_comm_reset), .tx_comm_wake(b_comm_wake),
      .tx_dout(b_dout), .tx_is_k(b_is_k), .tx_set_elec_idle(b_elec_idle), .linkup(b_linkup),
      .platform_error(b_error), .retry_count(b_retry), .lax_state(b_state)
   );

   // Reference model: state number, cycles spent in it, retries, and the current run length
   typedef struct packed {
      int st;
      int age;
      int retry;
      int run;
   } mstate_t;

   mstate_t m;
   bit      m_valid = 1'b0;

   function automatic int limit_of(int st);
      case (st)
         1:       return P_RESET;
         2:       return P_INIT_TO;
         3:       return P_NOINIT;
         4:       return P_WAKE;
         5:       return P_WAKE_TO;
         7, 9:    return P_ALIGN_TO;
         default: return 0;
      endcase
   endfunction

   function automatic mstate_t model_next(mstate_t c);
      mstate_t n = c;
      bit to, aln, syn, give_up;
      to      = c.age >= limit_of(c.st);
      aln     = (rx_is_k != 4'd0) && rx_din == ALIGN_W && rx_byte_is_aligned;
      syn     = (rx_is_k != 4'd0) && rx_din == SYNC_W;
      give_up = 1'b0;
      if (!platform_ready && c.st != 0 && c.st != 11) n.st = 0;
      else begin
         case (c.st)
            0:  if (platform_ready) n.st = 1;
            1:  if (to || tx_oob_complete) n.st = 2;
            2:  if (comm_init_detect) n.st = 3; else if (to) give_up = 1'b1;
            3:  if (!comm_init_detect && (to || tx_oob_complete)) n.st = 4;
            4:  if (to || tx_oob_complete) n.st = 5;
            5:  if (comm_wake_detect) n.st = 6; else if (to) give_up = 1'b1;
            6:  if (!comm_wake_detect) n.st = 7;
            7:  if (aln) n.st = 8; else if (to) give_up = 1'b1;
            8:  if (aln) n.run = 0;
                else if (c.run + 1 >= P_REL) n.st = 9;
                else n.run = c.run + 1;
            9:  if (syn) n.st = 10; else if (to) give_up = 1'b1;
            10: if (comm_init_detect) n.st = 0;
                else if (rx_is_elec_idle) begin
                   if (c.run + 1 >= P_LOSS) n.st = 0; else n.run = c.run + 1;
                end else n.run = 0;
            11: if (!platform_ready) begin n.st = 0; n.retry = 0; end
            default: n.st = 0;
         endcase
      end
      if (give_up) begin
         if (c.retry + 1 == P_MAX) n.st = 11;
         else begin n.retry = c.retry + 1; n.st = 0; end
      end
      if (n.st == 10) n.retry = 0;
      if (n.st != c.st) begin n.age = 0; n.run = 0; end
      else n.age = c.age + 1;
      return n;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m       <= '0;
         m_valid <= 1'b1;
      end else if (m_valid) begin
         m <= model_next(m);
      end
   end

   // State-change log and strobe counts for sequence-level expectations
   logic [3:0] last_st = 4'd0;
   logic [3:0] seq[$];
   int n_rst_str = 0;
   int n_wake_str = 0;

   always @(negedge clk) begin
      if (lax_state != last_st) seq.push_back(lax_state);
      last_st <= lax_state;
      if (tx_comm_reset) n_rst_str <= n_rst_str + 1;
      if (tx_comm_wake)  n_wake_str <= n_wake_str + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      bit on_line;
      on_line = (m.st >= 7 && m.st <= 10);
      chk("lax_state", {28'd0, lax_state}, m.st);
      chk("tx_comm_reset", {31'd0, tx_comm_reset}, {31'd0, m.st == 1 && m.age == 0});
      chk("tx_comm_wake", {31'd0, tx_comm_wake}, {31'd0, m.st == 4 && m.age == 0});
      chk("tx_set_elec_idle", {31'd0, tx_set_elec_idle}, {31'd0, !on_line});
      chk("tx_is_k", {31'd0, tx_is_k}, {31'd0, on_line && m.st != 7});
      chk("tx_dout", tx_dout, (m.st == 7) ? DIAL_W : (on_line ? ALIGN_W : 32'd0));
      chk("linkup", {31'd0, linkup}, {31'd0, m.st == 10});
      chk("platform_error", {31'd0, platform_error}, {31'd0, m.st == 11});
      chk("retry_count", {28'd0, retry_count}, m.retry);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_state(input logic [3:0] s, input int budget, input string name);
      int k = 0;
      while (lax_state != s && k < budget) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (lax_state != s) begin
         errors++;
         $display("FAIL %s: state %h, expected %h within %0d cycles", name, lax_state, s, budget);
      end
   endtask

   task automatic rx_set(input logic [31:0] d, input logic [3:0] k, input logic a);
      rx_din = d;
      rx_is_k = k;
      rx_byte_is_aligned = a;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      platform_ready = 1'b0;
      tx_oob_complete = 1'b0;
      comm_init_detect = 1'b0;
      comm_wake_detect = 1'b0;
      rx_is_elec_idle = 1'b0;
      rx_set(32'd0, 4'd0, 1'b0);
      step(3);
      rst = 1'b0;
      step(1);
   endtask

   task automatic handshake_to_align();
      platform_ready = 1'b1;
      wait_state(4'h2, 20, "reach_wait_init");
      comm_init_detect = 1'b1;
      step(20);
      comm_init_detect = 1'b0;
      wait_state(4'h5, 40, "reach_wait_wake");
      comm_wake_detect = 1'b1;
      step(20);
      comm_wake_detect = 1'b0;
      wait_state(4'h7, 10, "reach_wait_align");
   endtask

   initial begin
      int base_seq, base_rst, base_wake;

      fork
         forever begin
            @(negedge clk);
            if (m_valid) compare_all();
         end
      join_none

      // reset values
      do_reset();
      chk("reset_state", {28'd0, lax_state}, 32'h0);
      chk("reset_elec_idle", {31'd0, tx_set_elec_idle}, 32'h1);
      chk("reset_dout", tx_dout, 32'h0);

      // full handshake, then the no-SYNC variant reaching READY at the release point
      base_seq = seq.size();
      base_rst = n_rst_str;
      base_wake = n_wake_str;
      handshake_to_align();
      chk("wait_align_dout", tx_dout, DIAL_W);
      rx_set(ALIGN_W, 4'b0001, 1'b1);
      step(8);
      rx_set(32'h0, 4'd0, 1'b1);
      step(3);
      chk("hs_three_misses", {28'd0, lax_state}, 32'h8);
      step(1);
      chk("hs_fourth_miss", {28'd0, lax_state}, 32'h9);
      chk("nosync_ready", {28'd0, b_state}, 32'hA);
      chk("nosync_linkup", {31'd0, b_linkup}, 32'h1);
      rx_set(SYNC_W, 4'b0001, 1'b0);
      step(1);
      chk("hs_ready", {28'd0, lax_state}, 32'hA);
      chk("hs_linkup", {31'd0, linkup}, 32'h1);
      chk("hs_retry", {28'd0, retry_count}, 32'h0);
      step(1);
      chk("hs_seq_len", seq.size() - base_seq, 32'd10);
      for (int i = 0; i < 10; i++)
         if (base_seq + i < seq.size())
            chk("hs_seq_order", {28'd0, seq[base_seq + i]}, i + 1);
      chk("hs_reset_strobes", n_rst_str - base_rst, 32'd1);
      chk("hs_wake_strobes", n_wake_str - base_wake, 32'd1);

      // link loss: 15 idle cycles hold, 16 drop
      rx_is_elec_idle = 1'b1;
      step(15);
      rx_is_elec_idle = 1'b0;
      step(1);
      chk("loss15_linkup", {31'd0, linkup}, 32'h1);
      rx_is_elec_idle = 1'b1;
      step(16);
      chk("loss16_state", {28'd0, lax_state}, 32'h0);
      chk("loss16_linkup", {31'd0, linkup}, 32'h0);
      rx_is_elec_idle = 1'b0;

      // second handshake shortened by tx_oob_complete, then COMINIT in READY
      rx_set(32'h0, 4'd0, 1'b0);
      wait_state(4'h1, 5, "reach_send_reset");
      tx_oob_complete = 1'b1;
      step(1);
      tx_oob_complete = 1'b0;
      chk("oob_complete_exit", {28'd0, lax_state}, 32'h2);
      handshake_to_align();
      rx_set(ALIGN_W, 4'b0001, 1'b1);
      step(1);
      rx_set(32'h0, 4'd0, 1'b1);
      step(4);
      rx_set(SYNC_W, 4'b0001, 1'b0);
      step(1);
      chk("hs2_ready", {28'd0, lax_state}, 32'hA);
      comm_init_detect = 1'b1;
      step(1);
      comm_init_detect = 1'b0;
      chk("init_in_ready_state", {28'd0, lax_state}, 32'h0);
      chk("init_in_ready_linkup", {31'd0, linkup}, 32'h0);

      // ALIGN glitch, then DETECT_SYNC timeout without SYNC
      do_reset();
      handshake_to_align();
      rx_set(ALIGN_W, 4'b0001, 1'b1);
      step(1);
      rx_set(32'h0, 4'd0, 1'b1);
      step(2);
      chk("glitch_two_misses", {28'd0, lax_state}, 32'h8);
      rx_set(ALIGN_W, 4'b0001, 1'b1);
      step(1);
      rx_set(32'h0, 4'd0, 1'b1);
      step(3);
      chk("glitch_three_misses", {28'd0, lax_state}, 32'h8);
      step(1);
      chk("glitch_fourth_miss", {28'd0, lax_state}, 32'h9);
      wait_state(4'h0, 40, "sync_timeout");
      chk("sync_timeout_retry", {28'd0, retry_count}, 32'h1);
      platform_ready = 1'b0;
      step(2);

      // no COMINIT: one retry, then FAIL, then release by platform_ready low
      do_reset();
      platform_ready = 1'b1;
      wait_state(4'h2, 10, "nocominit_wait_init");
      wait_state(4'h0, 60, "nocominit_first_timeout");
      chk("nocominit_retry1", {28'd0, retry_count}, 32'h1);
      chk("nocominit_err0", {31'd0, platform_error}, 32'h0);
      wait_state(4'hB, 80, "nocominit_fail");
      chk("fail_error", {31'd0, platform_error}, 32'h1);
      platform_ready = 1'b0;
      step(1);
      chk("fail_exit_state", {28'd0, lax_state}, 32'h0);
      chk("fail_exit_error", {31'd0, platform_error}, 32'h0);
      chk("fail_exit_retry", {28'd0, retry_count}, 32'h0);

      // platform_ready drop mid-sequence
      platform_ready = 1'b1;
      wait_state(4'h2, 10, "drop_wait_init");
      comm_init_detect = 1'b1;
      step(3);
      comm_init_detect = 1'b0;
      wait_state(4'h5, 40, "drop_wait_wake");
      platform_ready = 1'b0;
      step(1);
      chk("drop_state", {28'd0, lax_state}, 32'h0);
      chk("drop_retry", {28'd0, retry_count}, 32'h0);

      // rst in WAIT_ALIGN
      do_reset();
      handshake_to_align();
      rst = 1'b1;
      step(1);
      chk("rst_state", {28'd0, lax_state}, 32'h0);
      chk("rst_dout", tx_dout, 32'h0);
      chk("rst_is_k", {31'd0, tx_is_k}, 32'h0);
      chk("rst_elec_idle", {31'd0, tx_set_elec_idle}, 32'h1);
      chk("rst_strobes", {30'd0, tx_comm_reset, tx_comm_wake}, 32'h0);
      chk("rst_linkup", {31'd0, linkup}, 32'h0);
      rst = 1'b0;
      platform_ready = 1'b0;
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
